// File: rtl/clock_divider_bank.sv
// clock_divider_bank: bank of independent 50%-duty clock dividers driven from
// one source clock, with glitch-free ratio updates, graceful stop and a
// global phase-align strobe.
module clock_divider_bank #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 1,
    localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_valid,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic                cfg_ready,
    output logic [CHANNELS-1:0] out_clk,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] cfg_pending
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING
    } ch_state_t;

    logic             ch_in_range;
    logic             cfg_accept;
    logic [CNT_W-1:0] cfg_div_eff;

    assign ch_in_range = (32'(cfg_ch) < CHANNELS);
    assign cfg_accept  = cfg_valid && cfg_ready;
    // A half-period of zero is meaningless; treat it as the fastest ratio.
    assign cfg_div_eff = (cfg_div == '0) ? CNT_W'(1) : cfg_div;

    // Ready unless the target channel already holds a staged ratio (or does not exist).
    always_comb begin
        cfg_ready = 1'b0;
        if (rst && ch_in_range) begin
            cfg_ready = ~cfg_pending[cfg_ch];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        ch_state_t        state_q;
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] staged_q;
        logic [CNT_W-1:0] div_m1;
        logic             out_q;
        logic             tick_q;
        logic             pend_q;
        logic             hit;
        logic             wrap;

        assign div_m1 = div_q - CNT_W'(1);
        assign hit    = cfg_accept && (cfg_ch == CH_W'(g));
        assign wrap   = (cnt_q == div_m1);

        assign out_clk[g]     = out_q;
        assign tick[g]        = tick_q;
        assign cfg_pending[g] = pend_q;

        // Per-channel divider state machine: counting, staging, stop and sync handling.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q  <= ST_IDLE;
                div_q    <= CNT_W'(DEFAULT_DIV);
                staged_q <= CNT_W'(DEFAULT_DIV);
                cnt_q    <= '0;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
                pend_q   <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (sync && state_q != ST_IDLE) begin
                    // Phase-align: restart the low phase, take the newest ratio at once.
                    cnt_q  <= '0;
                    out_q  <= 1'b0;
                    pend_q <= 1'b0;
                    if (hit) begin
                        div_q <= cfg_div_eff;
                    end else if (pend_q) begin
                        div_q <= staged_q;
                    end
                    state_q <= (state_q == ST_STOPPING) ? ST_IDLE : ST_RUN;
                end else if (state_q == ST_IDLE) begin
                    cnt_q <= '0;
                    out_q <= 1'b0;
                    if (hit) begin
                        div_q <= cfg_div_eff;
                    end
                    if (en[g]) begin
                        state_q <= ST_RUN;
                    end
                end else if (state_q == ST_RUN && !en[g] && !out_q) begin
                    // Disabled during the low phase: stop now, keep any ratio for the restart.
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    pend_q  <= 1'b0;
                    if (hit) begin
                        div_q <= cfg_div_eff;
                    end else if (pend_q) begin
                        div_q <= staged_q;
                    end
                end else if (wrap) begin
                    cnt_q  <= '0;
                    out_q  <= ~out_q;
                    tick_q <= ~out_q;
                    if (out_q) begin
                        // Falling edge is the period boundary: a ratio arriving now is
                        // applied directly since the new period starts cleanly.
                        pend_q <= 1'b0;
                        if (hit) begin
                            div_q <= cfg_div_eff;
                        end else if (pend_q) begin
                            div_q <= staged_q;
                        end
                        state_q <= en[g] ? ST_RUN : ST_IDLE;
                    end else if (hit) begin
                        pend_q   <= 1'b1;
                        staged_q <= cfg_div_eff;
                    end
                end else begin
                    cnt_q   <= cnt_q + CNT_W'(1);
                    state_q <= en[g] ? ST_RUN : ST_STOPPING;
                    if (hit) begin
                        pend_q   <= 1'b1;
                        staged_q <= cfg_div_eff;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Scoreboard bench for clock_divider_bank: stimulus schedules expected output
// values per clk cycle, a negedge monitor compares whatever is due.
module tb_clock_divider_bank;

    localparam int KOUT  = 0;
    localparam int KTICK = 1;
    localparam int KPEND = 2;
    localparam int KRDY  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] en = 4'b0000;
    logic       sync = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_ready;
    logic [3:0] out_clk;
    logic [3:0] tick;
    logic [3:0] cfg_pending;

    clock_divider_bank #(
        .CHANNELS   (4),
        .CNT_W      (8),
        .DEFAULT_DIV(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sync       (sync),
        .cfg_valid  (cfg_valid),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .out_clk    (out_clk),
        .tick       (tick),
        .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        int   kind;
        int   ch;
        logic val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic string kname(input int kind);
        case (kind)
            KOUT:    return "out_clk";
            KTICK:   return "tick";
            KPEND:   return "cfg_pending";
            default: return "cfg_ready";
        endcase
    endfunction

    function automatic logic sample(input int kind, input int ch);
        case (kind)
            KOUT:    return out_clk[ch];
            KTICK:   return tick[ch];
            KPEND:   return cfg_pending[ch];
            default: return cfg_ready;
        endcase
    endfunction

    function automatic void chk(input string nm, input int ch, input logic act, input logic exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s ch%0d cyc%0d: got %b expected %b", nm, ch, cyc, act, exp_v);
        end
    endfunction

    function automatic void push(input int c, input int kind, input int ch, input logic v);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.ch   = ch;
        e.val  = v;
        sb.push_back(e);
    endfunction

    // Ideal divider started in its low phase at cycle base: out = floor(k/d) mod 2.
    function automatic void push_wave(input int ch, input int base, input int d, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            push(base + k, KOUT, ch, logic'(((k / d) % 2) == 1));
            push(base + k, KTICK, ch, logic'((k % (2 * d)) == d));
        end
    endfunction

    function automatic void push_zero(input int c, input logic with_ready);
        for (int ch = 0; ch < 4; ch++) begin
            push(c, KOUT, ch, 1'b0);
            push(c, KTICK, ch, 1'b0);
            push(c, KPEND, ch, 1'b0);
        end
        if (with_ready) push(c, KRDY, 0, 1'b0);
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk(kname(sb[i].kind), sb[i].ch, sample(sb[i].kind, sb[i].ch), sb[i].val);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL stale_%s ch%0d: got unchecked expected check at cyc%0d", kname(sb[i].kind), sb[i].ch, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic reset_rel(input logic [3:0] en_v, output int c);
        step();
        rst = 1'b0; en = 4'b0000; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
        push_zero(cyc, 1'b1);
        step();
        push_zero(cyc, 1'b1);
        step();
        rst = 1'b1;
        en  = en_v;
        c   = cyc;
    endtask

    initial begin
        int c, b, bs, bs2, b3, bp;

        // Defaults: divide-by-2 in phase, then staged ratio updates.
        reset_rel(4'b1111, c);
        b = c + 1;
        push_wave(0, b, 1, 0, 29);
        push_wave(3, b, 1, 0, 29);
        push_wave(1, b, 1, 0, 21);
        push_wave(2, b, 1, 0, 9);
        step_to(b + 8);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3;
        push(b + 8, KRDY, 0, 1'b1);
        step_to(b + 9);
        cfg_div = 8'd7;
        push(b + 9, KRDY, 0, 1'b0);
        push(b + 9, KPEND, 2, 1'b1);
        step_to(b + 10);
        cfg_valid = 1'b0;
        push(b + 10, KPEND, 2, 1'b0);
        push_wave(2, b + 10, 3, 0, 12);
        step_to(b + 19);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd1;
        push(b + 19, KRDY, 0, 1'b1);
        step_to(b + 20);
        cfg_ch = 2'd1; cfg_div = 8'd2;
        push(b + 20, KPEND, 2, 1'b1);
        push(b + 20, KRDY, 0, 1'b1);
        step_to(b + 21);
        cfg_ch = 2'd2; cfg_div = 8'd5;
        push(b + 21, KPEND, 1, 1'b1);
        push(b + 21, KPEND, 2, 1'b1);
        push(b + 21, KRDY, 0, 1'b0);
        step_to(b + 22);
        cfg_valid = 1'b0;
        push(b + 22, KPEND, 1, 1'b0);
        push(b + 22, KPEND, 2, 1'b0);
        push_wave(2, b + 22, 1, 0, 5);
        push_wave(1, b + 22, 2, 0, 7);
        step_to(b + 30);

        // Idle configuration, then sync phase alignment of D=5 and D=2.
        reset_rel(4'b0000, c);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
        push(c + 1, KPEND, 0, 1'b0);
        push(c + 1, KOUT, 0, 1'b0);
        step_to(c + 1);
        cfg_ch = 2'd1; cfg_div = 8'd2;
        push(c + 2, KPEND, 1, 1'b0);
        step_to(c + 2);
        cfg_valid = 1'b0; en = 4'b0011;
        b = c + 3;
        push_wave(0, b, 5, 0, 6);
        push_wave(1, b, 2, 0, 6);
        step_to(b + 6);
        sync = 1'b1;
        step_to(b + 7);
        sync = 1'b0;
        bs = b + 7;
        push_wave(0, bs, 5, 0, 25);
        push_wave(1, bs, 2, 0, 25);
        push(bs, KOUT, 2, 1'b0);
        step_to(bs + 25);
        sync = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
        step_to(bs + 26);
        sync = 1'b0; cfg_valid = 1'b0;
        bs2 = bs + 26;
        push_wave(0, bs2, 2, 0, 7);
        push_wave(1, bs2, 2, 0, 7);
        push(bs2, KPEND, 0, 1'b0);
        push(bs2, KOUT, 3, 1'b0);
        step_to(bs2 + 8);

        // Graceful stop on ch3 with D=4, restart, and re-enable while stopping.
        reset_rel(4'b0000, c);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd4;
        step_to(c + 1);
        cfg_valid = 1'b0; en = 4'b1000;
        b = c + 2;
        push_wave(3, b, 4, 0, 4);
        step_to(b + 4);
        en = 4'b0000;
        for (int k = 5; k <= 12; k++) begin
            push(b + k, KOUT, 3, logic'(k <= 7));
            push(b + k, KTICK, 3, 1'b0);
        end
        push(b + 5, KOUT, 0, 1'b0);
        step_to(b + 12);
        en = 4'b1000;
        b3 = b + 13;
        push_wave(3, b3, 4, 0, 15);
        step_to(b3 + 4);
        en = 4'b0000;
        step_to(b3 + 5);
        en = 4'b1000;
        step_to(b3 + 16);

        // Asynchronous reset mid-period discards a staged zero ratio.
        reset_rel(4'b0001, c);
        b = c + 1;
        push_wave(0, b, 1, 0, 4);
        step_to(b + 4);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
        step_to(b + 5);
        cfg_valid = 1'b0;
        chk("pend_before_rst", 0, cfg_pending[0], 1'b1);
        chk("out_before_rst", 0, out_clk[0], 1'b1);
        #2;
        rst = 1'b0;
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            chk("async_out", ch, out_clk[ch], 1'b0);
            chk("async_tick", ch, tick[ch], 1'b0);
            chk("async_pend", ch, cfg_pending[ch], 1'b0);
        end
        chk("async_ready", 0, cfg_ready, 1'b0);
        push_zero(b + 5, 1'b1);
        push_zero(b + 6, 1'b0);
        step_to(b + 6);
        rst = 1'b1;
        bp = b + 7;
        push_wave(0, bp, 1, 0, 9);
        step_to(bp + 2);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
        step_to(bp + 3);
        cfg_valid = 1'b0;
        push(bp + 3, KPEND, 0, 1'b1);
        push(bp + 4, KPEND, 0, 1'b0);
        step_to(bp + 12);

        foreach (sb[i]) begin
            total++;
            bad++;
            $display("FAIL leftover_%s ch%0d: got unchecked expected check at cyc%0d", kname(sb[i].kind), sb[i].ch, sb[i].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
